// File: rtl/imm_arbiter.sv
// imm_arbiter: two requesters share one immediate-extension unit feeding a valid/ready output register.
// Optional build macro IMM_ARB_RR_EN selects round-robin tie-breaking (default: requester 0 wins ties).
module imm_arbiter #(
   parameter bit RR_INIT = 1'b0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  req,
   input  logic [1:0]  fmt0,
   input  logic [1:0]  fmt1,
   input  logic [25:0] raw0,
   input  logic [25:0] raw1,
   output logic [1:0]  gnt,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] out_imm,
   output logic        out_id
);
   typedef enum logic [1:0] {FMT_D = 2'b00, FMT_I = 2'b01, FMT_CB = 2'b10, FMT_B = 2'b11} fmt_t;
   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

   state_t      state;
   logic        free;
   logic        tie_pick;
   logic [1:0]  sel_fmt;
   logic [25:0] sel_raw;
   logic [63:0] ext_imm;

   assign out_valid = (state == FULL);
   assign free      = (state == EMPTY) || out_ready;

`ifdef IMM_ARB_RR_EN
   logic prio;

   assign tie_pick = prio;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)     prio <= RR_INIT;
      else if (|gnt) prio <= ~gnt[1];
   end
`else
   logic unused_rr_init;

   assign unused_rr_init = RR_INIT;
   assign tie_pick       = 1'b0;
`endif

   always_comb begin
      // NOTE: default assignment first so every path drives gnt; without it a latch is inferred.
      gnt = 2'b00;
      if (free) begin
         case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = tie_pick ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
         endcase
      end
   end

   // Only the granted requester's field reaches the extender; the result is registered before leaving.
   assign sel_fmt = gnt[1] ? fmt1 : fmt0;
   assign sel_raw = gnt[1] ? raw1 : raw0;

   always_comb begin
      ext_imm = '0;
      case (fmt_t'(sel_fmt))
         FMT_D:   ext_imm = {{55{sel_raw[8]}}, sel_raw[8:0]};
         FMT_I:   ext_imm = {52'd0, sel_raw[11:0]};
         FMT_CB:  ext_imm = {{43{sel_raw[18]}}, sel_raw[18:0], 2'b00};
         FMT_B:   ext_imm = {{36{sel_raw[25]}}, sel_raw[25:0], 2'b00};
         default: ext_imm = '0;
      endcase
   end

   // NOTE: registers use non-blocking assignments so every flop samples pre-edge values together.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= EMPTY;
         out_imm <= '0;
         out_id  <= 1'b0;
      end else begin
         case (state)
            EMPTY: begin
               if (|gnt) begin
                  state   <= FULL;
                  out_imm <= ext_imm;
                  out_id  <= gnt[1];
               end
            end
            FULL: begin
               if (|gnt) begin
                  out_imm <= ext_imm;
                  out_id  <= gnt[1];
               end else if (out_ready) begin
                  state <= EMPTY;
               end
            end
            default: state <= EMPTY;
         endcase
      end
   end
endmodule

// File: tb/tb_imm_arbiter.sv
// Self-checking bench for imm_arbiter: vector table, directed corner sequences and a
// randomized run against an arithmetic reference model (tracks IMM_ARB_RR_EN).
module tb_imm_arbiter;
   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  req;
   logic [1:0]  fmt0, fmt1;
   logic [25:0] raw0, raw1;
   logic [1:0]  gnt;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_imm;
   logic        out_id;

   int checks   = 0;
   int failures = 0;

   imm_arbiter #(.RR_INIT(1'b0)) dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .fmt0      (fmt0),
      .fmt1      (fmt1),
      .raw0      (raw0),
      .raw1      (raw1),
      .gnt       (gnt),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_imm   (out_imm),
      .out_id    (out_id)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

   // Reference model state
   logic        m_valid;
   logic        m_id;
   logic [63:0] m_imm;
`ifdef IMM_ARB_RR_EN
   logic        m_prio;
`endif
   logic [1:0]  last_g;

   typedef struct {
      logic [1:0]  req;
      logic [1:0]  fmt;
      logic [25:0] raw;
      logic [63:0] imm;
   } vec_t;

   vec_t vecs [10];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Immediate value as a signed integer, then shifted by multiplication.
   function automatic logic [63:0] model_ext(input logic [1:0] f, input logic [25:0] r);
      longint v;
      v = 0;
      case (f)
         2'd0: begin v[8:0] = r[8:0]; if (r[8]) v = v - 512; end
         2'd1: v[11:0] = r[11:0];
         2'd2: begin v[18:0] = r[18:0]; if (r[18]) v = v - 524288; v = v * 4; end
         default: begin v[25:0] = r[25:0]; if (r[25]) v = v - 67108864; v = v * 4; end
      endcase
      return $unsigned(v);
   endfunction

   function automatic logic [1:0] model_gnt(input logic [1:0] r, input logic rdy);
      int w;
      if ((m_valid && !rdy) || r == 2'b00) return 2'b00;
      if (r == 2'b11) begin
`ifdef IMM_ARB_RR_EN
         w = int'(m_prio);
`else
         w = 0;
`endif
      end else begin
         w = int'(r[1]);
      end
      return (w == 1) ? 2'b10 : 2'b01;
   endfunction

   task automatic model_reset();
      m_valid = 1'b0;
      m_id    = 1'b0;
      m_imm   = '0;
`ifdef IMM_ARB_RR_EN
      m_prio  = 1'b0;
`endif
   endtask

   // One clock: check combinational grant mid-cycle, then registered outputs #1 after the edge.
   task automatic cycle(input string tag);
      logic [1:0] eg;
      #1;
      eg = model_gnt(req, out_ready);
      check({tag, " gnt"}, 64'(gnt), 64'(eg));
      @(posedge clk);
      #1;
      if (|eg) begin
         m_valid = 1'b1;
         m_id    = eg[1];
         m_imm   = eg[1] ? model_ext(fmt1, raw1) : model_ext(fmt0, raw0);
`ifdef IMM_ARB_RR_EN
         m_prio  = ~eg[1];
`endif
      end else if (out_ready) begin
         m_valid = 1'b0;
      end
      last_g = eg;
      check({tag, " out_valid"}, 64'(out_valid), 64'(m_valid));
      check({tag, " out_imm"}, out_imm, m_imm);
      check({tag, " out_id"}, 64'(out_id), 64'(m_id));
   endtask

   initial begin
      logic [1:0]  pend;
      logic        exp_id;
      logic [63:0] held;

      vecs[0] = '{2'b01, 2'd0, 26'h00001FC, 64'hFFFF_FFFF_FFFF_FFFC};
      vecs[1] = '{2'b10, 2'd3, 26'h3FFFFFF, 64'hFFFF_FFFF_FFFF_FFFC};
      vecs[2] = '{2'b10, 2'd2, 26'h0000010, 64'h0000_0000_0000_0040};
      vecs[3] = '{2'b01, 2'd1, 26'h0000FFF, 64'h0000_0000_0000_0FFF};
      vecs[4] = '{2'b01, 2'd0, 26'h3FFFC0F, 64'h0000_0000_0000_000F};
      vecs[5] = '{2'b01, 2'd1, 26'h3FFF800, 64'h0000_0000_0000_0800};
      vecs[6] = '{2'b10, 2'd2, 26'h0040000, 64'hFFFF_FFFF_FFF0_0000};
      vecs[7] = '{2'b10, 2'd3, 26'h1FFFFFF, 64'h0000_0000_07FF_FFFC};
      vecs[8] = '{2'b01, 2'd2, 26'h003FFFF, 64'h0000_0000_000F_FFFC};
      vecs[9] = '{2'b10, 2'd0, 26'h0000100, 64'hFFFF_FFFF_FFFF_FF00};

      reset = 1'b1; req = 2'b00; fmt0 = '0; fmt1 = '0; raw0 = '0; raw1 = '0; out_ready = 1'b1;
      model_reset();
      @(posedge clk);
      #1;
      check("reset out_valid", 64'(out_valid), 64'd0);
      check("reset out_imm", out_imm, 64'd0);
      check("reset out_id", 64'(out_id), 64'd0);
      req = 2'b10;
      #1;
      check("reset gnt", 64'(gnt), 64'(2'b10));
      req = 2'b00;
      reset = 1'b0;

      // Single-requester vectors; the idle requester's fields are garbage to prove selection.
      for (int i = 0; i < 10; i++) begin
         req = vecs[i].req;
         out_ready = 1'b1;
         if (vecs[i].req[1]) begin
            fmt1 = vecs[i].fmt; raw1 = vecs[i].raw;
            fmt0 = 2'($urandom()); raw0 = 26'($urandom());
         end else begin
            fmt0 = vecs[i].fmt; raw0 = vecs[i].raw;
            fmt1 = 2'($urandom()); raw1 = 26'($urandom());
         end
         cycle("vec");
         check("vec table imm", out_imm, vecs[i].imm);
         check("vec table id", 64'(out_id), 64'(vecs[i].req[1]));
      end

      // Both requesters held for six cycles starting from a fresh reset.
      reset = 1'b1;
      #1;
      reset = 1'b0;
      model_reset();
      req = 2'b11; fmt0 = 2'd0; raw0 = 26'd1; fmt1 = 2'd1; raw1 = 26'd2; out_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         cycle("both");
`ifdef IMM_ARB_RR_EN
         exp_id = k[0];
`else
         exp_id = 1'b0;
`endif
         check("both id seq", 64'(out_id), 64'(exp_id));
      end

      // Backpressure: result held and no grant while out_ready is low.
      req = 2'b01; fmt0 = 2'd0; raw0 = 26'd5; out_ready = 1'b1;
      cycle("bp load");
      held = out_imm;
      check("bp loaded", held, 64'd5);
      req = 2'b01; fmt0 = 2'd1; raw0 = 26'h123; out_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         cycle("bp hold");
         check("bp gnt zero", 64'(gnt), 64'd0);
         check("bp imm stable", out_imm, held);
      end
      out_ready = 1'b1;
      #1;
      check("bp release gnt", 64'(gnt), 64'(2'b01));
      cycle("bp release");
      check("bp new imm", out_imm, 64'h123);
      check("bp no bubble", 64'(out_valid), 64'd1);

      // Idle drain.
      req = 2'b00;
      cycle("drain");
      check("drain valid", 64'(out_valid), 64'd0);
      cycle("drain2");
      check("drain stays", 64'(out_valid), 64'd0);

      // Asynchronous reset mid-cycle while FULL, with a held request surviving it.
      req = 2'b10; fmt1 = 2'd3; raw1 = 26'h3FFFFFF;
      cycle("ar load");
      check("ar full", 64'(out_valid), 64'd1);
      req = 2'b00;
      #2;
      reset = 1'b1;
      #1;
      check("ar valid", 64'(out_valid), 64'd0);
      check("ar imm", out_imm, 64'd0);
      check("ar id", 64'(out_id), 64'd0);
      req = 2'b10; fmt1 = 2'd1; raw1 = 26'h0AB;
      @(posedge clk);
      #1;
      check("ar held valid", 64'(out_valid), 64'd0);
      reset = 1'b0;
      model_reset();
      cycle("ar post");
      check("ar post id", 64'(out_id), 64'd1);
      check("ar post imm", out_imm, 64'h0AB);

      // Randomized traffic honouring the hold-until-granted rule.
      pend = 2'b00;
      req = 2'b00;
      for (int n = 0; n < 400; n++) begin
         if (!pend[0]) begin
            pend[0] = ($urandom_range(0, 2) != 0);
            fmt0 = 2'($urandom());
            raw0 = 26'($urandom());
         end
         if (!pend[1]) begin
            pend[1] = ($urandom_range(0, 2) != 0);
            fmt1 = 2'($urandom());
            raw1 = 26'($urandom());
         end
         req = pend;
         out_ready = ($urandom_range(0, 3) != 0);
         cycle("rnd");
         pend = pend & ~last_g;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
